ioctl_rom_router: RTL and testbench

- Parametrised successor to the core's inline download handling (ROM stream plus DIP latch at index 254).
- Accepts the HPS ioctl 16-bit write stream and routes ROM words into NUM_REGIONS equal-size memory regions through a FIFO with a req/ack memory port.
- Drives ioctl_wait back-pressure, captures DIP bytes, and produces rom_init/rom_done sequencing for the core.
- Sits between hps_io and the SDRAM/BRAM ROM stores in the emu top.

---
 rtl/ioctl_rom_router.sv | 269 ++++++++++++++++++++++++++
 tb/tb_ioctl_rom_router.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_rom_router.sv
`default_nettype none
// ============================================================================
//  Module   : ioctl_rom_router
//  Purpose  : Routes the HPS ioctl 16-bit download stream into NUM_REGIONS
//             equal-size ROM regions through a small write FIFO with a
//             req/ack memory port, latches DIP switch bytes, drives
//             ioctl_wait back-pressure and sequences rom_init / rom_done.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_sys, reset          system clock, asynchronous active-high reset
//    ioctl_download/index/   HPS download stream (write strobe, byte
//    wr/addr/dout            address, 16-bit data)
//    ioctl_wait              back-pressure to HPS (occupancy >= DEPTH-2)
//    mem_req/region/addr/    memory write port; outputs held until
//    data, mem_ack           mem_ack is sampled with mem_req high
//    dip_out                 captured DIP bytes, byte k at [8k+7:8k]
//    rom_init, rom_done      load-in-progress / all words committed
//    err_flags               sticky: [0] FIFO overflow, [1] addr out of range
//    checksum                additive checksum of accepted words
//  Option macro
//    IOCTL_ROM_ROUTER_CHECKSUM_EN : builds the checksum accumulator; when
//    undefined, checksum is tied to zero.
// ============================================================================
module ioctl_rom_router #(
    parameter logic [7:0]           ROM_INDEX   = 8'd0,
    parameter logic [7:0]           DIP_INDEX   = 8'd254,
    parameter int                   NUM_REGIONS = 4,
    parameter int                   REGION_AW   = 16,
    parameter int                   FIFO_DEPTH  = 8,
    parameter int                   NUM_DIP     = 8,
    parameter logic [8*NUM_DIP-1:0] DIP_RESET   = {(8*NUM_DIP){1'b1}}
) (
    input  logic                                                   clk_sys,
    input  logic                                                   reset,
    input  logic                                                   ioctl_download,
    input  logic [7:0]                                             ioctl_index,
    input  logic                                                   ioctl_wr,
    input  logic [26:0]                                            ioctl_addr,
    input  logic [15:0]                                            ioctl_dout,
    output logic                                                   ioctl_wait,
    output logic                                                   mem_req,
    output logic [((NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1)-1:0] mem_region,
    output logic [REGION_AW-1:0]                                   mem_addr,
    output logic [15:0]                                            mem_data,
    input  logic                                                   mem_ack,
    output logic [8*NUM_DIP-1:0]                                   dip_out,
    output logic                                                   rom_init,
    output logic                                                   rom_done,
    output logic [1:0]                                             err_flags,
    output logic [15:0]                                            checksum
);

    localparam int RSEL_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int ENT_W  = RSEL_W + REGION_AW + 16;

    // First word address past the last region.
    localparam logic [26:0] WORD_LIMIT = 27'(NUM_REGIONS) << REGION_AW;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [ENT_W-1:0]       fifo_mem_q [FIFO_DEPTH];
    logic [ENT_W-1:0]       fifo_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   mem_req_q, mem_req_d;
    logic [RSEL_W-1:0]      mem_region_q, mem_region_d;
    logic [REGION_AW-1:0]   mem_addr_q, mem_addr_d;
    logic [15:0]            mem_data_q, mem_data_d;
    logic [1:0]             err_q, err_d;
    logic [8*NUM_DIP-1:0]   dip_q, dip_d;

    logic [25:0]            w_word;
    logic                   w_in_range;
    logic                   w_rom_wr;
    logic                   w_push_req;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_overflow;
    logic                   w_oor;
    logic                   w_load_entry;

    // ------------------------------------------------------------------
    // Write decode
    // ------------------------------------------------------------------
    assign w_word       = ioctl_addr[26:1];
    assign w_in_range   = ({1'b0, w_word} < WORD_LIMIT);
    assign w_rom_wr     = (state_q == ST_LOAD) && ioctl_wr && (ioctl_index == ROM_INDEX);
    assign w_push_req   = w_rom_wr && w_in_range;
    assign w_oor        = w_rom_wr && !w_in_range;
    assign w_full       = (count_q == CNT_W'(FIFO_DEPTH));
    assign w_pop        = mem_req_q && mem_ack;
    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // is still accepted then.
    assign w_push       = w_push_req && (!w_full || w_pop);
    assign w_overflow   = w_push_req && w_full && !w_pop;
    assign w_load_entry = ((state_q == ST_IDLE) || (state_q == ST_DONE)) &&
                          ioctl_download && (ioctl_index == ROM_INDEX);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (w_load_entry) state_d = ST_LOAD;
            ST_LOAD:  if (!ioctl_download) state_d = ST_DRAIN;
            ST_DRAIN: if ((count_q == '0) && !mem_req_q) state_d = ST_DONE;
            ST_DONE:  if (w_load_entry) state_d = ST_LOAD;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO. The entry presented on the memory port stays counted until
    // it is acknowledged, so occupancy covers everything not yet written.
    // ------------------------------------------------------------------
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (w_push) begin
            fifo_mem_d[wr_ptr_q] = {w_word[REGION_AW +: RSEL_W],
                                    w_word[REGION_AW-1:0],
                                    ioctl_dout};
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (w_push && !w_pop) begin
            count_d = count_q + 1'b1;
        end else if (!w_push && w_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Memory port: load the head entry when idle, hold until acknowledged.
    // The cycle after a pop always has mem_req low, giving 1 word / 2 cycles.
    // ------------------------------------------------------------------
    always_comb begin
        mem_req_d    = mem_req_q;
        mem_region_d = mem_region_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        if (w_pop) begin
            mem_req_d = 1'b0;
        end else if (!mem_req_q && (count_q != '0)) begin
            mem_req_d = 1'b1;
            {mem_region_d, mem_addr_d, mem_data_d} = fifo_mem_q[rd_ptr_q];
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags, cleared on every entry into LOAD
    // ------------------------------------------------------------------
    always_comb begin
        err_d = err_q;
        if (w_load_entry) begin
            err_d = 2'b00;
        end else begin
            if (w_overflow) err_d[0] = 1'b1;
            if (w_oor)      err_d[1] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // DIP capture, independent of FSM state
    // ------------------------------------------------------------------
    always_comb begin
        dip_d = dip_q;
        if (ioctl_wr && (ioctl_index == DIP_INDEX)) begin
            for (int k = 0; k < NUM_DIP; k++) begin
                if (ioctl_addr == 27'(k)) begin
                    dip_d[8*k +: 8] = ioctl_dout[7:0];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            mem_req_q    <= 1'b0;
            mem_region_q <= '0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            err_q        <= 2'b00;
            dip_q        <= DIP_RESET;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            mem_req_q    <= mem_req_d;
            mem_region_q <= mem_region_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            err_q        <= err_d;
            dip_q        <= dip_d;
        end
    end

    // Storage needs no reset: pointers and count define validity.
    always_ff @(posedge clk_sys) begin
        fifo_mem_q <= fifo_mem_d;
    end

    // ------------------------------------------------------------------
    // Optional checksum of accepted words
    // ------------------------------------------------------------------
`ifdef IOCTL_ROM_ROUTER_CHECKSUM_EN
    logic [15:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (w_load_entry) begin
            checksum_d = 16'h0000;
        end else if (w_push) begin
            checksum_d = checksum_q + ioctl_dout;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            checksum_q <= 16'h0000;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = 16'h0000;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ioctl_wait = (count_q >= CNT_W'(FIFO_DEPTH - 2));
    assign mem_req    = mem_req_q;
    assign mem_region = mem_region_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign dip_out    = dip_q;
    assign rom_init   = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    assign rom_done   = (state_q == ST_DONE);
    assign err_flags  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ioctl_rom_router.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ioctl_rom_router
//  Purpose  : Directed self-checking bench for ioctl_rom_router with default
//             parameters (4 regions x 64K words, 8-entry FIFO, 8 DIP bytes).
//  Revision : 1.0  initial release
// ============================================================================
module tb_ioctl_rom_router;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [26:0] ioctl_addr = '0;
    logic [15:0] ioctl_dout = '0;
    logic        ioctl_wait;
    logic        mem_req;
    logic [1:0]  mem_region;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_ack;
    logic [63:0] dip_out;
    logic        rom_init;
    logic        rom_done;
    logic [1:0]  err_flags;
    logic [15:0] checksum;

    logic        ack_en = 1'b0;
    logic [33:0] got_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          sent;

    ioctl_rom_router dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .mem_req        (mem_req),
        .mem_region     (mem_region),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .mem_ack        (mem_ack),
        .dip_out        (dip_out),
        .rom_init       (rom_init),
        .rom_done       (rom_done),
        .err_flags      (err_flags),
        .checksum       (checksum)
    );

    always #5 clk_sys = ~clk_sys;

    // Memory responder: acknowledges immediately while enabled.
    assign mem_ack = ack_en & mem_req;

    // Record every committed word as {region, addr, data}.
    always @(posedge clk_sys) begin
        if (!reset && mem_req && mem_ack) begin
            got_q.push_back({mem_region, mem_addr, mem_data});
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic hps_write(input logic [7:0] idx, input logic [26:0] addr, input logic [15:0] data);
        tick();
        ioctl_index = idx;
        ioctl_addr  = addr;
        ioctl_dout  = data;
        ioctl_wr    = 1'b1;
        tick();
        ioctl_wr    = 1'b0;
    endtask

    task automatic start_download();
        tick();
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        tick();
    endtask

    task automatic wait_done(input string tag);
        int c;
        c = 0;
        while (!rom_done && c < 300) begin
            tick();
            c++;
        end
        check(tag, {63'd0, rom_done}, 64'd1);
    endtask

    task automatic check_got(input string tag, input int i, input logic [33:0] exp);
        if (i < got_q.size()) check(tag, {30'd0, got_q[i]}, {30'd0, exp});
        else                  check(tag, 64'hDEAD_0000_0000_0000, {30'd0, exp});
    endtask

    initial begin
        // ---------------- reset state ----------------
        repeat (3) tick();
        check("rst_mem_req",   {63'd0, mem_req}, 64'd0);
        check("rst_wait",      {63'd0, ioctl_wait}, 64'd0);
        check("rst_init_done", {62'd0, rom_init, rom_done}, 64'd0);
        check("rst_err",       {62'd0, err_flags}, 64'd0);
        check("rst_dip",       dip_out, 64'hFFFF_FFFF_FFFF_FFFF);
        check("rst_cksum",     {48'd0, checksum}, 64'd0);
        reset = 1'b0;

        // ---------------- basic routing + latency ----------------
        ack_en = 1'b1;
        start_download();
        check("t1_rom_init", {63'd0, rom_init}, 64'd1);
        hps_write(8'd0, 27'h0000000, 16'h1111);
        check("t1_lat_t1", {63'd0, mem_req}, 64'd0);
        tick();
        check("t1_lat_t2", {63'd0, mem_req}, 64'd1);
        hps_write(8'd0, 27'h0000002, 16'h2222);
        hps_write(8'd0, 27'h0020000, 16'h3333);
        ioctl_download = 1'b0;
        wait_done("t1_done_timeout");
        check("t1_count", 64'(got_q.size()), 64'd3);
        check_got("t1_w0", 0, {2'd0, 16'h0000, 16'h1111});
        check_got("t1_w1", 1, {2'd0, 16'h0001, 16'h2222});
        check_got("t1_w2", 2, {2'd1, 16'h0000, 16'h3333});
        check("t1_init_off", {63'd0, rom_init}, 64'd0);
        check("t1_err", {62'd0, err_flags}, 64'd0);
`ifdef IOCTL_ROM_ROUTER_CHECKSUM_EN
        check("t1_cksum", {48'd0, checksum}, 64'h6666);
`else
        check("t1_cksum", {48'd0, checksum}, 64'h0000);
`endif

        // ---------------- back-pressure obeyed ----------------
        got_q.delete();
        ack_en = 1'b0;
        start_download();
        sent = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (!ioctl_wait && sent < 10) begin
                ioctl_index = 8'd0;
                ioctl_addr  = 27'(2 * sent);
                ioctl_dout  = 16'hA000 + 16'(sent);
                ioctl_wr    = 1'b1;
                sent++;
            end else begin
                ioctl_wr = 1'b0;
            end
        end
        check("t2_sent_at_wait", 64'(sent), 64'd6);
        check("t2_wait_high", {63'd0, ioctl_wait}, 64'd1);
        check("t2_no_ovf", {62'd0, err_flags}, 64'd0);
        ack_en = 1'b1;
        for (int c = 0; c < 100 && sent < 10; c++) begin
            tick();
            if (!ioctl_wait) begin
                ioctl_addr = 27'(2 * sent);
                ioctl_dout = 16'hA000 + 16'(sent);
                ioctl_wr   = 1'b1;
                sent++;
            end else begin
                ioctl_wr = 1'b0;
            end
        end
        tick();
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
        wait_done("t2_done_timeout");
        check("t2_count", 64'(got_q.size()), 64'd10);
        for (int i = 0; i < 10; i++) begin
            check_got("t2_word", i, {2'd0, 16'(i), 16'hA000 + 16'(i)});
        end
        check("t2_err_end", {62'd0, err_flags}, 64'd0);
`ifdef IOCTL_ROM_ROUTER_CHECKSUM_EN
        check("t2_cksum", {48'd0, checksum}, 64'h402D);
`endif

        // ---------------- overflow when wait ignored ----------------
        got_q.delete();
        ack_en = 1'b0;
        start_download();
        for (int i = 0; i < 10; i++) begin
            ioctl_index = 8'd0;
            ioctl_addr  = 27'(2 * i);
            ioctl_dout  = 16'hB000 + 16'(i);
            ioctl_wr    = 1'b1;
            tick();
        end
        ioctl_wr = 1'b0;
        check("t3_ovf_flag", {62'd0, err_flags}, 64'd1);
        ack_en = 1'b1;
        ioctl_download = 1'b0;
        wait_done("t3_done_timeout");
        check("t3_count", 64'(got_q.size()), 64'd8);
        check_got("t3_last", 7, {2'd0, 16'h0007, 16'hB007});
        check("t3_err_sticky", {62'd0, err_flags}, 64'd1);
`ifdef IOCTL_ROM_ROUTER_CHECKSUM_EN
        check("t3_cksum", {48'd0, checksum}, 64'h801C);
`endif

        // ---------------- out-of-range address ----------------
        got_q.delete();
        start_download();
        check("t4_err_cleared", {62'd0, err_flags}, 64'd0);
        hps_write(8'd0, 27'h0080000, 16'hDEAD);
        hps_write(8'd0, 27'h007FFFE, 16'h1234);
        ioctl_download = 1'b0;
        wait_done("t4_done_timeout");
        check("t4_oor_flag", {62'd0, err_flags}, 64'd2);
        check("t4_count", 64'(got_q.size()), 64'd1);
        check_got("t4_top_word", 0, {2'd3, 16'hFFFF, 16'h1234});
`ifdef IOCTL_ROM_ROUTER_CHECKSUM_EN
        check("t4_cksum", {48'd0, checksum}, 64'h1234);
`endif
        start_download();
        check("t4_err_reclear", {62'd0, err_flags}, 64'd0);
        ioctl_download = 1'b0;
        wait_done("t4b_done_timeout");

        // ---------------- DIP capture ----------------
        hps_write(8'd254, 27'd0, 16'h00A5);
        hps_write(8'd254, 27'd3, 16'h003C);
        hps_write(8'd254, 27'd9, 16'h00FF);
        hps_write(8'd254, 27'd8, 16'h0011);
        check("t5_dip", dip_out, 64'hFFFF_FFFF_3CFF_FFA5);
        check("t5_flags", {62'd0, rom_init, rom_done}, 64'd1);

        // ---------------- reset mid-DRAIN ----------------
        got_q.delete();
        ack_en = 1'b0;
        start_download();
        hps_write(8'd0, 27'd0, 16'h0001);
        hps_write(8'd0, 27'd2, 16'hFFFF);
        hps_write(8'd0, 27'd4, 16'h0005);
        ioctl_download = 1'b0;
        tick();
        check("t6_drain_init", {62'd0, rom_init, rom_done}, 64'd2);
`ifdef IOCTL_ROM_ROUTER_CHECKSUM_EN
        check("t6_cksum", {48'd0, checksum}, 64'h0005);
`endif
        reset = 1'b1;
        tick();
        check("t6_rst_req", {63'd0, mem_req}, 64'd0);
        check("t6_rst_init", {63'd0, rom_init}, 64'd0);
        check("t6_rst_wait", {63'd0, ioctl_wait}, 64'd0);
        check("t6_rst_cksum", {48'd0, checksum}, 64'd0);
        reset  = 1'b0;
        ack_en = 1'b1;
        repeat (10) tick();
        check("t6_no_words", 64'(got_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
